morse_letter_ctrl: RTL and testbench

Sequencer for the Morse keyer front end. It samples the raw dot and dash buttons at a divided tick rate, debounces and edge-detects them, and assembles up to four symbols into one letter code. Each completed letter is handed to the downstream decoder/display over a valid/ready handshake. It replaces the free-running per-button counting with a single clocked controller that owns letter framing.

---
 rtl/morse_letter_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_morse_letter_ctrl.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_letter_ctrl.sv
// morse_letter_ctrl: samples the raw dot/dash keys on a divided tick,
// edge-detects them and frames up to four symbols into one letter code.
//
// Ports:
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   btn_dot_n   raw dot key, active-low
//   btn_dash_n  raw dash key, active-low
//   code        letter symbols, first in bit 0, 1=dash 0=dot
//   code_len    number of valid symbols (1..4 while code_valid)
//   code_valid  letter pending for the consumer
//   code_ready  consumer accepts the pending letter
//   drop        1-clk pulse: press discarded while a letter is pending
//
// Build option: define MORSE_GAP_COMMIT_EN to commit a partial letter
// after GAP_TICKS sample ticks without a press.

module morse_letter_ctrl #(
    parameter int unsigned TICK_DIV  = 250000,
    parameter int unsigned GAP_TICKS = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_dot_n,
    input  logic       btn_dash_n,
    output logic [3:0] code,
    output logic [2:0] code_len,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       drop
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    if (TICK_DIV < 2 || GAP_TICKS < 1) begin : g_cfg_check
        $error("morse_letter_ctrl: need TICK_DIV>=2, GAP_TICKS>=1");
    end

    logic [TW-1:0] tick_cnt;
    logic          tick;

    logic dot_s1;
    logic dot_s2;
    logic dash_s1;
    logic dash_s2;

    logic ev_dot;
    logic ev_dash;
    logic ev_one;
    logic ev_both;
    logic gap_hit;

    state_t     state;
    state_t     state_n;
    logic [3:0] code_n;
    logic [2:0] len_n;
    logic       drop_n;
    logic       start;

    // Sample tick divider
    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + TW'(1);
        end
    end

    // Two-stage samplers advance only on tick, so a rising
    // s1 & ~s2 is seen on exactly one tick per press.
    always_ff @(posedge clk) begin
        if (rst) begin
            dot_s1  <= 1'b0;
            dot_s2  <= 1'b0;
            dash_s1 <= 1'b0;
            dash_s2 <= 1'b0;
        end else if (tick) begin
            dot_s1  <= ~btn_dot_n;
            dot_s2  <= dot_s1;
            dash_s1 <= ~btn_dash_n;
            dash_s2 <= dash_s1;
        end
    end

    assign ev_dot  = tick & dot_s1 & ~dot_s2;
    assign ev_dash = tick & dash_s1 & ~dash_s2;
    assign ev_one  = ev_dot ^ ev_dash;
    assign ev_both = ev_dot & ev_dash;

`ifdef MORSE_GAP_COMMIT_EN
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    logic [GW-1:0] gap_cnt;

    // Held at zero outside COLLECT, so it enters COLLECT cleared;
    // any press restarts the idle count.
    always_ff @(posedge clk) begin
        if (rst || state != S_COLLECT || ev_dot || ev_dash) begin
            gap_cnt <= '0;
        end else if (tick) begin
            gap_cnt <= gap_cnt + GW'(1);
        end
    end

    assign gap_hit = tick & (gap_cnt == GAP_LAST);
`else
    assign gap_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        code_n  = code;
        len_n   = code_len;
        drop_n  = 1'b0;
        start   = 1'b0;

        unique case (state)
            S_IDLE: begin
                start = 1'b1;
            end
            S_COLLECT: begin
                if (ev_both) begin
                    state_n = S_HOLD;
                end else if (ev_one) begin
                    code_n[code_len[1:0]] = ev_dash;
                    len_n = code_len + 3'd1;
                    if (code_len == 3'd3) begin
                        state_n = S_HOLD;
                    end
                end else if (gap_hit) begin
                    state_n = S_HOLD;
                end
            end
            S_HOLD: begin
                // A press on the handshake cycle belongs
                // to the next letter, not to drop.
                if (code_ready) begin
                    start = 1'b1;
                end else begin
                    drop_n = ev_dot | ev_dash;
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (start) begin
            code_n  = '0;
            len_n   = '0;
            state_n = S_IDLE;
            if (ev_one) begin
                code_n  = {3'b000, ev_dash};
                len_n   = 3'd1;
                state_n = S_COLLECT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            code     <= '0;
            code_len <= '0;
            drop     <= 1'b0;
        end else begin
            state    <= state_n;
            code     <= code_n;
            code_len <= len_n;
            drop     <= drop_n;
        end
    end

    assign code_valid = (state == S_HOLD);

endmodule

// File: tb/tb_morse_letter_ctrl.sv
// tb_morse_letter_ctrl: directed and random checks of the Morse
// letter sequencer against a symbol-queue reference model.

module tb_morse_letter_ctrl;

    localparam int TD = 4;
    localparam int GT = 8;
`ifdef MORSE_GAP_COMMIT_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_dot_n;
    logic       btn_dash_n;
    logic [3:0] code;
    logic [2:0] code_len;
    logic       code_valid;
    logic       code_ready;
    logic       drop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    morse_letter_ctrl #(
        .TICK_DIV  (TD),
        .GAP_TICKS (GT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_dot_n  (btn_dot_n),
        .btn_dash_n (btn_dash_n),
        .code       (code),
        .code_len   (code_len),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .drop       (drop)
    );

    // Reference model: the letter is a queue of symbols; a pending
    // letter is a flag; the tick is the cycle number mod TD.
    int   m_cyc = 0;
    bit   md1, md2, ma1, ma2;
    bit   m_hold = 0;
    bit   m_drop = 0;
    int   m_gap  = 0;
    bit   m_syms[$];
    logic [3:0] exp_code  = '0;
    logic [2:0] exp_len   = '0;
    logic       exp_valid = 1'b0;
    logic       exp_drop  = 1'b0;

    always @(posedge clk) begin
        bit tk, ed, ea, xfer;
        if (rst) begin
            m_cyc = 0;
            md1 = 0; md2 = 0; ma1 = 0; ma2 = 0;
            m_syms.delete();
            m_hold = 0;
            m_gap  = 0;
            m_drop = 0;
        end else begin
            tk = (m_cyc % TD) == TD - 1;
            m_cyc++;
            ed = tk && md1 && !md2;
            ea = tk && ma1 && !ma2;
            if (tk) begin
                md2 = md1; md1 = !btn_dot_n;
                ma2 = ma1; ma1 = !btn_dash_n;
            end
            m_drop = 0;
            xfer = m_hold && code_ready;
            if (m_hold && !xfer) begin
                m_drop = ed || ea;
            end else begin
                if (xfer) begin
                    m_hold = 0;
                    m_syms.delete();
                end
                if (ed && ea) begin
                    if (m_syms.size() > 0) m_hold = 1;
                end else if (ed || ea) begin
                    m_syms.push_back(ea);
                    m_gap = 0;
                    if (m_syms.size() == 4) m_hold = 1;
                end else if (tk && m_syms.size() > 0) begin
                    m_gap++;
                    if (GAP_EN && m_gap == GT) m_hold = 1;
                end
            end
        end
        exp_valid = m_hold;
        exp_drop  = m_drop;
        exp_len   = 3'(m_syms.size());
        exp_code  = '0;
        foreach (m_syms[i]) exp_code[i] = m_syms[i];
    end

    task automatic do_reset();
        rst        = 1'b1;
        btn_dot_n  = 1'b1;
        btn_dash_n = 1'b1;
        code_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic key(input bit dot, input bit dash,
                       input int hold_t, input int rel_t);
        btn_dot_n  = !dot;
        btn_dash_n = !dash;
        repeat (hold_t * TD) @(negedge clk);
        btn_dot_n  = 1'b1;
        btn_dash_n = 1'b1;
        repeat (rel_t * TD) @(negedge clk);
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        btn_dot_n  = 1'b0;
        btn_dash_n = 1'b0;
        code_ready = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (code !== 4'd0) begin
            failures++;
            $display("FAIL reset_code got=%0h want=0", code);
        end
        checks++;
        if (code_len !== 3'd0) begin
            failures++;
            $display("FAIL reset_len got=%0d want=0", code_len);
        end
        checks++;
        if (code_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", code_valid);
        end
        checks++;
        if (drop !== 1'b0) begin
            failures++;
            $display("FAIL reset_drop got=%b want=0", drop);
        end
        rst        = 1'b0;
        btn_dot_n  = 1'b1;
        btn_dash_n = 1'b1;
        code_ready = 1'b0;
    endtask

    task automatic test_four_symbols();
        logic [3:0] pat = 4'b1010;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 6 * TD; c++) begin
                btn_dot_n  = !(c < 3 * TD && !pat[s]);
                btn_dash_n = !(c < 3 * TD && pat[s]);
                @(negedge clk);
                checks++;
                if (code_valid !== exp_valid) begin
                    failures++;
                    $display("FAIL four_valid_timing s=%0d c=%0d got=%b want=%b",
                             s, c, code_valid, exp_valid);
                end
            end
        end
        checks++;
        if (code !== 4'b1010) begin
            failures++;
            $display("FAIL four_code got=%b want=1010", code);
        end
        checks++;
        if (code_len !== 3'd4) begin
            failures++;
            $display("FAIL four_len got=%0d want=4", code_len);
        end
        checks++;
        if (code_valid !== 1'b1) begin
            failures++;
            $display("FAIL four_valid got=%b want=1", code_valid);
        end
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        checks++;
        if (code_valid !== 1'b0 || code_len !== 3'd0) begin
            failures++;
            $display("FAIL four_accept got=%b/%0d want=0/0",
                     code_valid, code_len);
        end
    endtask

    task automatic test_gap();
        do_reset();
        key(1'b0, 1'b1, 2, 6);
        checks++;
        if (code_valid !== 1'b0 || code_len !== 3'd1) begin
            failures++;
            $display("FAIL gap_early got=%b/%0d want=0/1",
                     code_valid, code_len);
        end
        repeat (4 * TD) @(negedge clk);
        checks++;
        if (code_valid !== GAP_EN) begin
            failures++;
            $display("FAIL gap_valid got=%b want=%b", code_valid, GAP_EN);
        end
        checks++;
        if (code !== 4'b0001 || code_len !== 3'd1) begin
            failures++;
            $display("FAIL gap_code got=%b/%0d want=0001/1",
                     code, code_len);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 0; c < TD - 1; c++) begin
            btn_dot_n = c[0];
            @(negedge clk);
        end
        btn_dot_n = 1'b0;
        for (int c = 0; c < 50 * TD; c++) begin
            @(negedge clk);
            checks++;
            if (code_len !== exp_len || drop !== exp_drop) begin
                failures++;
                $display("FAIL bounce_track c=%0d got=%0d/%b want=%0d/%b",
                         c, code_len, drop, exp_len, exp_drop);
            end
        end
        btn_dot_n = 1'b1;
        repeat (3 * TD) @(negedge clk);
        checks++;
        if (code_len !== 3'd1 || code !== 4'd0) begin
            failures++;
            $display("FAIL bounce_len got=%0d/%b want=1/0000",
                     code_len, code);
        end
        checks++;
        if (code_valid !== GAP_EN) begin
            failures++;
            $display("FAIL bounce_valid got=%b want=%b",
                     code_valid, GAP_EN);
        end
    endtask

    task automatic test_drop();
        logic [3:0] pat = 4'b1001;
        int ndrop = 0;
        do_reset();
        for (int s = 0; s < 4; s++) key(!pat[s], pat[s], 2, 2);
        btn_dot_n = 1'b0;
        for (int c = 0; c < 5 * TD; c++) begin
            if (c == 3 * TD) btn_dot_n = 1'b1;
            @(negedge clk);
            if (drop === 1'b1) ndrop++;
            checks++;
            if (drop !== exp_drop) begin
                failures++;
                $display("FAIL drop_timing c=%0d got=%b want=%b",
                         c, drop, exp_drop);
            end
        end
        checks++;
        if (ndrop != 1) begin
            failures++;
            $display("FAIL drop_count got=%0d want=1", ndrop);
        end
        checks++;
        if (code !== 4'b1001 || code_len !== 3'd4 || code_valid !== 1'b1) begin
            failures++;
            $display("FAIL drop_frozen got=%b/%0d/%b want=1001/4/1",
                     code, code_len, code_valid);
        end
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        checks++;
        if (code_valid !== 1'b0 || code_len !== 3'd0 || code !== 4'd0) begin
            failures++;
            $display("FAIL drop_accept got=%b/%0d/%b want=0/0/0000",
                     code_valid, code_len, code);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        key(1'b1, 1'b0, 2, 2);
        key(1'b0, 1'b1, 2, 2);
        checks++;
        if (code_len !== 3'd2 || code !== 4'b0010) begin
            failures++;
            $display("FAIL mid_pre got=%0d/%b want=2/0010", code_len, code);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (code !== 4'd0 || code_len !== 3'd0 ||
            code_valid !== 1'b0 || drop !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst got=%b/%0d/%b/%b want=0/0/0/0",
                     code, code_len, code_valid, drop);
        end
        key(1'b1, 1'b0, 2, 1);
        checks++;
        if (code_len !== 3'd1 || code !== 4'd0 || code_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_fresh got=%0d/%b/%b want=1/0000/0",
                     code_len, code, code_valid);
        end
    endtask

    task automatic test_commit();
        do_reset();
        key(1'b1, 1'b0, 2, 2);
        key(1'b1, 1'b0, 2, 2);
        key(1'b1, 1'b1, 2, 2);
        checks++;
        if (code !== 4'b0000 || code_len !== 3'd2 || code_valid !== 1'b1) begin
            failures++;
            $display("FAIL commit got=%b/%0d/%b want=0000/2/1",
                     code, code_len, code_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        key(1'b0, 1'b1, 2, 2);
        key(1'b1, 1'b1, 2, 2);
        checks++;
        if (code_valid !== 1'b1 || code !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_hold got=%b/%b want=1/0001",
                     code_valid, code);
        end
        btn_dot_n = 1'b0;
        for (int k = 0; k < TD && (m_cyc % TD) != TD - 1; k++)
            @(negedge clk);
        repeat (TD) @(negedge clk);
        code_ready = 1'b1;
        @(negedge clk);
        code_ready = 1'b0;
        checks++;
        if (code_valid !== 1'b0 || code_len !== 3'd1 ||
            code !== 4'd0 || drop !== 1'b0) begin
            failures++;
            $display("FAIL b2b_new got=%b/%0d/%b/%b want=0/1/0000/0",
                     code_valid, code_len, code, drop);
        end
        btn_dot_n = 1'b1;
        repeat (2 * TD) @(negedge clk);
        checks++;
        if (code_len !== exp_len || code_valid !== exp_valid) begin
            failures++;
            $display("FAIL b2b_after got=%0d/%b want=%0d/%b",
                     code_len, code_valid, exp_len, exp_valid);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) btn_dot_n = !btn_dot_n;
            if ($urandom_range(0, 7) == 0) btn_dash_n = !btn_dash_n;
            code_ready = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
            checks++;
            if (code !== exp_code || code_len !== exp_len) begin
                failures++;
                $display("FAIL rand_code c=%0d got=%b/%0d want=%b/%0d",
                         c, code, code_len, exp_code, exp_len);
            end
            checks++;
            if (code_valid !== exp_valid || drop !== exp_drop) begin
                failures++;
                $display("FAIL rand_flags c=%0d got=%b/%b want=%b/%b",
                         c, code_valid, drop, exp_valid, exp_drop);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        btn_dot_n  = 1'b1;
        btn_dash_n = 1'b1;
        code_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_four_symbols();
        test_gap();
        test_bounce();
        test_drop();
        test_reset_mid();
        test_commit();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
